// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- four-digit multiplexed 7-segment (+dp) scan controller.
//
// Cycles through digits 0..3. Each digit is shown for DIGIT_CYCLES clocks.
// It is then followed by BLANK_CYCLES clocks with every segment and digit off,
// which suppresses ghosting between digits. A level interrupt is raised each
// time a full frame completes.
//
// Ports
//   clk        clock, rising edge
//   resetb     asynchronous active-low reset
//   enable     scan enable (level); low returns to IDLE with everything off
//   wr_en      pattern write strobe
//   wr_addr    digit index to write
//   wr_data    segment pattern {a,b,c,d,e,f,g,h}, 1 = lit
//   irq_ack    clears frame_irq (a simultaneous new frame completion wins)
//   abcdefgh   segment drive, active-low, registered
//   digit      digit select, active-low one-hot, registered
//   cur_digit  index being scanned (0 in IDLE)
//   frame_irq  frame-complete interrupt request, level
module seg7_scan_ctrl #(
   parameter int DIGIT_CYCLES = 12500,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       enable,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       irq_ack,
   output logic [7:0] abcdefgh,
   output logic [3:0] digit,
   output logic [1:0] cur_digit,
   output logic       frame_irq
);

   localparam int MAX_DWELL = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W     = (MAX_DWELL > 0) ? $clog2(MAX_DWELL + 1) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             irq_set;
   logic [7:0]       pat [4];
   logic [7:0]       seg_nxt;
   logic [3:0]       dig_nxt;

   // pattern registers, writable in any state
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < 4; i++) pat[i] <= 8'h00;
      end else if (wr_en) begin
         pat[wr_addr] <= wr_data;
      end
   end

   // next-state logic; cnt counts cycles already spent in the current dwell
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + 1'b1;
      irq_set   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            if (enable) state_nxt = SHOW;
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               cnt_nxt = '0;
               if (BLANK_CYCLES > 0) begin
                  state_nxt = BLANK;
               end else begin
                  idx_nxt = idx + 2'd1;
                  irq_set = (idx == 2'd3);
               end
            end
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               cnt_nxt   = '0;
               state_nxt = SHOW;
               idx_nxt   = idx + 2'd1;
               irq_set   = (idx == 2'd3);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
      // disabling overrides everything, including a frame completion
      if (!enable) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         cnt_nxt   = '0;
         irq_set   = 1'b0;
      end
   end

   // outputs are decoded from the next state so the registers line up with it
   always_comb begin
      seg_nxt = 8'hFF;
      dig_nxt = 4'hF;
      if (state_nxt == SHOW) begin
         seg_nxt = ~pat[idx_nxt];
         dig_nxt = ~(4'b0001 << idx_nxt);
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         abcdefgh  <= 8'hFF;
         digit     <= 4'hF;
         frame_irq <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         abcdefgh  <= seg_nxt;
         digit     <= dig_nxt;
         frame_irq <= irq_set | (frame_irq & ~irq_ack);
      end
   end

   // idx is forced to 0 in IDLE, so it doubles as the scanned-index output
   assign cur_digit = idx;

endmodule
